// File: rtl/filter_readout_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_readout_sched_if : valid/ready readout stream carrying per-channel peaks
// Revision: 1.0
// ----------------------------------------------------------------------------
interface filter_readout_sched_if #(
  parameter int N_CH             = 8,
  parameter int SIZE_FILTER_DATA = 16
);
  localparam int CH_W = $clog2(N_CH);

  logic                        out_valid;
  logic                        out_ready;
  logic [SIZE_FILTER_DATA-1:0] out_data;
  logic [CH_W-1:0]             out_ch;
  logic                        out_last;

  modport master (
    output out_valid, out_data, out_ch, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_ch, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/filter_readout_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_readout_sched : windowed signed peak capture per channel, then ordered readout
// Revision: 1.0
// ----------------------------------------------------------------------------
module filter_readout_sched #(
  parameter int N_CH             = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SIZE_WIN         = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [SIZE_WIN-1:0]                win_len,
  input  logic [N_CH-1:0]                    ch_en,
  input  logic [N_CH*SIZE_FILTER_DATA-1:0]   input_data,
  output logic                               busy,
  output logic                               done,
  filter_readout_sched_if.master             out_if
);
  localparam int CH_W = $clog2(N_CH);
  localparam int SFD  = SIZE_FILTER_DATA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  logic [SIZE_WIN-1:0]   win_len_q;
  logic [SIZE_WIN-1:0]   acq_cnt;
  logic [N_CH-1:0]       ch_en_q;
  logic [N_CH-1:0]       pending;
  logic signed [SFD-1:0] peak     [N_CH];
  logic signed [SFD-1:0] peak_nxt [N_CH];

  logic [SIZE_WIN-1:0]   win_eff;
  logic                  acq_first;
  logic                  acq_last;
  logic [N_CH-1:0]       rest;
  logic [CH_W-1:0]       first_idx;
  logic [CH_W-1:0]       next_idx;
  logic                  first_last;
  logic                  next_last;

  function automatic logic [CH_W-1:0] lowest(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  function automatic logic only_one_left(input logic [N_CH-1:0] m, input logic [CH_W-1:0] idx);
    return (m & ~(N_CH'(1) << idx)) == '0;
  endfunction

  // A zero window still takes one sample.
  assign win_eff    = (win_len_q == '0) ? SIZE_WIN'(1) : win_len_q;
  assign acq_first  = (acq_cnt == '0);
  assign acq_last   = (acq_cnt == win_eff - SIZE_WIN'(1));

  assign first_idx  = lowest(ch_en_q);
  assign first_last = only_one_left(ch_en_q, first_idx);
  assign rest       = pending & ~(N_CH'(1) << out_if.out_ch);
  assign next_idx   = lowest(rest);
  assign next_last  = only_one_left(rest, next_idx);

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic signed [SFD-1:0] sample;
      assign sample      = input_data[g*SFD +: SFD];
      assign peak_nxt[g] = (ch_en_q[g] && (acq_first || (sample > peak[g]))) ? sample : peak[g];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      win_len_q        <= '0;
      ch_en_q          <= '0;
      acq_cnt          <= '0;
      pending          <= '0;
      for (int i = 0; i < N_CH; i++) peak[i] <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_ch    <= '0;
      out_if.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win_len_q <= win_len;
            ch_en_q   <= ch_en;
            acq_cnt   <= '0;
            busy      <= 1'b1;
            if (ch_en == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ACQ;
            end
          end
        end
        ACQ: begin
          for (int i = 0; i < N_CH; i++) peak[i] <= peak_nxt[i];
          acq_cnt <= acq_cnt + SIZE_WIN'(1);
          // The final sample is folded in via peak_nxt so the first word is ready on SEND entry.
          if (acq_last) begin
            state            <= SEND;
            pending          <= ch_en_q;
            out_if.out_valid <= 1'b1;
            out_if.out_ch    <= first_idx;
            out_if.out_data  <= peak_nxt[first_idx];
            out_if.out_last  <= first_last;
          end
        end
        SEND: begin
          if (out_if.out_ready) begin
            pending <= rest;
            if (out_if.out_last) begin
              out_if.out_valid <= 1'b0;
              out_if.out_last  <= 1'b0;
              state            <= DONE;
              done             <= 1'b1;
            end else begin
              out_if.out_ch    <= next_idx;
              out_if.out_data  <= peak[next_idx];
              out_if.out_last  <= next_last;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/filter_readout_sched.md
FILTER_READOUT_SCHED -- requirements
Module: filter_readout_sched

Interface
REQ-001 Parameter N_CH, default 8: number of filter channels served, range 2..32.
REQ-002 Parameter SIZE_FILTER_DATA, default 16: width of each filter sample, two's-complement signed.
REQ-003 Parameter SIZE_WIN, default 8: width of the window-length input.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to begin a measurement; honoured only in IDLE.
REQ-007 Port win_len, input, SIZE_WIN: number of samples in the acquisition window; latched on accepted start.
REQ-008 Port ch_en, input, N_CH: per-channel enable mask; latched on accepted start.
REQ-009 Port input_data, input, N_CH*SIZE_FILTER_DATA: filter outputs, packed; channel i at bits [i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA].
REQ-010 Port out_valid, output, 1: out_data/out_ch/out_last are valid.
REQ-011 Port out_ready, input, 1: downstream accepts the word.
REQ-012 Port out_data, output, SIZE_FILTER_DATA: peak (signed maximum) of the channel.
REQ-013 Port out_ch, output, $clog2(N_CH): index of the channel in out_data.
REQ-014 Port out_last, output, 1: the current word is for the last enabled channel.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a measurement completes.

Function
REQ-017 The FSM SHALL have the states IDLE, ACQ, SEND and DONE.
REQ-018 IDLE: on start=1, the block SHALL latch win_len and ch_en; it SHALL go to DONE if the latched ch_en is 0, and to ACQ otherwise.
REQ-019 start SHALL be ignored in ACQ, SEND and DONE, with no effect on the latched configuration.
REQ-020 A latched win_len of 0 SHALL be treated as 1.
REQ-021 ACQ SHALL last exactly the effective window length in cycles, with one sample per cycle.
REQ-022 In the first ACQ cycle, each enabled channel's peak register SHALL load input_data unconditionally; in later ACQ cycles it SHALL load input_data only when input_data is strictly greater (signed compare).
REQ-023 Peak registers of disabled channels SHALL NOT be updated.
REQ-024 After the last ACQ cycle the FSM SHALL enter SEND; if start is accepted at cycle t, the first out_valid SHALL be high at cycle t+W+1, where W is the effective window length.
REQ-025 SEND: enabled channels SHALL be emitted in ascending index order, and disabled channels SHALL be skipped with no bubble cycles.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_ch and out_last SHALL hold stable.
REQ-027 A word SHALL transfer on a cycle with out_valid=1 and out_ready=1; the next enabled channel SHALL be presented on the following cycle.
REQ-028 out_last SHALL be 1 only with the highest-index enabled channel.
REQ-029 The transfer of the last word SHALL move the FSM to DONE, with out_valid=0 on the next cycle.
REQ-030 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE, where a new start is accepted.
REQ-031 out_ready SHALL be ignored when out_valid=0.
REQ-032 The peak compare SHALL be full SIZE_FILTER_DATA-width signed, with no saturation or truncation.

Reset
REQ-033 When reset=1, the next state SHALL be IDLE, and out_valid, out_data, out_ch, out_last, busy and done SHALL be 0.
REQ-034 The peak registers and latched configuration SHALL clear to 0 on reset.
REQ-035 Reset asserted in ACQ or SEND SHALL abort the measurement; no further words and no done pulse SHALL be produced.
REQ-036 reset SHALL take priority over a start on the same cycle.

Verification
REQ-037 N_CH=8, ch_en=0xFF, win_len=4, channel i ramps i, i+1, i+2, i+3, out_ready=1 -> first out_valid 5 cycles after start; 8 back-to-back words out_ch 0..7 with out_data i+3; out_last with ch 7; done one cycle later.
REQ-038 ch_en=0x24, win_len=3, samples for channel 2 = -5, -2, -9 and channel 5 = 7, 7, 1 -> exactly two words: (ch2, -2) then (ch5, 7, out_last=1).
REQ-039 Backpressure: out_ready toggles 0,0,1 repeatedly -> each word is held stable 3 cycles; no word is lost or duplicated; the order is unchanged.
REQ-040 ch_en=0 with start -> done one cycle after start; out_valid never asserts; busy is high for exactly 1 cycle.
REQ-041 win_len=0 -> behaves as win_len=1: the peak equals the first sample, and out_valid goes high 2 cycles after start.
REQ-042 Reset asserted in the middle of SEND after 3 of 8 words -> out_valid is 0 on the next cycle; no done pulse; a fresh start then runs a full 8-word measurement; a start pulsed during ACQ changes nothing.
